uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter START_ADDR, default 32'h0000_0000, first instruction-memory byte address written.
REQ-003 SHALL have ports:
 - clk  in  1  single clock; all logic on rising edge.
 - Rst_n  in  1  reset, asynchronous, active-low.
 - prog  in  1  programming-mode enable from the core bus.
 - rx  in  1  UART serial input; asynchronous, idle high.
 - imem_prog_ena  out  1  instruction memory owned by the loader.
 - imem_we  out  1  one-cycle word-write strobe.
 - imem_addr  out  32  byte address of the word being written.
 - imem_din  out  32  instruction word to write.
 - word_count  out  16  words written this session.
 - frame_err  out  1  sticky framing-error flag.
 - checksum  out  32  XOR of words written this session.

Function
REQ-004 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1.
REQ-005 SHALL run the RX FSM IDLE -> START -> DATA -> STOP -> IDLE, and SHALL hold it in IDLE while prog=0.
REQ-006 In IDLE, SHALL enter START on synchronized rx=0.
REQ-007 In START, after CLKS_PER_BIT/2 cycles, SHALL go to DATA if rx=0, else return to IDLE (glitch reject).
REQ-008 In DATA, SHALL sample 8 bits LSB-first at CLKS_PER_BIT-cycle intervals from mid-start.
REQ-009 In STOP, SHALL sample once at mid-bit. rx=1 gives a valid byte. rx=0 sets frame_err and discards the byte. Both cases return to IDLE.
REQ-010 SHALL place valid bytes little-endian into a word: byte index 0 -> [7:0], ... index 3 -> [31:24]. The index wraps 3 -> 0.
REQ-011 On the 4th byte, SHALL assert imem_we for exactly one cycle, 1 cycle after the stop-bit sample, with imem_din = the assembled word and imem_addr = the current address.
REQ-012 After each write, SHALL advance the address by 4, wrapping modulo 2^32, and SHALL increment word_count, saturating at 16'hFFFF.
REQ-013 imem_prog_ena SHALL equal prog registered one cycle.
REQ-014 On the rising edge of prog, SHALL load START_ADDR into the address and clear byte index, word_count, frame_err and checksum.
REQ-015 On the falling edge of prog, SHALL drop any partial word. Any write due in that same cycle SHALL be suppressed. An in-flight RX frame SHALL be abandoned.
REQ-016 imem_we SHALL never assert while imem_prog_ena=0.
REQ-017 A frame error SHALL NOT advance the byte index.

Reset
REQ-018 While Rst_n=0, all outputs SHALL be 0, the FSM SHALL be in IDLE, the address SHALL equal START_ADDR, and all counters SHALL be 0.
REQ-019 Reset mid-frame or mid-word SHALL discard all partial data.

Configuration
REQ-020 With UART_LOADER_CHECKSUM_EN defined, checksum SHALL be XORed with imem_din on every imem_we cycle and cleared per REQ-014.
REQ-021 Without UART_LOADER_CHECKSUM_EN, the checksum port SHALL remain present and be driven constant 0, with no checksum register.

Structure
REQ-022 Package uart_loader_pkg SHALL hold the RX state enum (IDLE, START, DATA, STOP), the byte-index width constant, and the default CLKS_PER_BIT.
REQ-023 Sub-module uart_rx_byte SHALL contain the synchronizer, baud counter and RX FSM, with outputs byte_valid, byte_data[7:0] and frame_err_pulse. uart_prog_loader SHALL contain word assembly, the address and counters, and the checksum.

Verification (bench CLKS_PER_BIT=16)
REQ-024 prog=1; send bytes 13,00,00,00,93,00,10,00 -> imem_we twice: (addr 0x0, din 0x00000013), then (addr 0x4, din 0x00100093); word_count=2.
REQ-025 prog=1; rx low pulse of 4 cycles -> no byte accepted; FSM returns to IDLE; no imem_we.
REQ-026 prog=1; send byte 0xAA with stop bit 0, then bytes 01,02,03,04 -> frame_err=1; single write din 0x04030201 at addr 0x0.
REQ-027 Send 3 bytes, drop prog, raise prog, send EF,BE,AD,DE -> one write only: addr 0x0, din 0xDEADBEEF; frame_err=0.
REQ-028 With UART_LOADER_CHECKSUM_EN defined, write words 0x12345678 and 0xFFFF0000 -> checksum=0xEDCB5678. Without the macro -> checksum=0.
REQ-029 Assert Rst_n=0 during the DATA bits of byte 2 -> all outputs 0 during reset. After release, with prog=1 (rising edge seen), 4 new bytes produce a write at START_ADDR.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader: RX state encoding,
// byte-lane index width and the default baud divisor.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int BYTE_IDX_W = 2;

  // 100 MHz clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the loader while it owns the memory.
// Handshake: imem_we is a one-cycle strobe that writes imem_din at imem_addr;
// the memory always accepts it, and it is only ever raised while imem_prog_ena=1.
interface uart_prog_loader_if;
  logic        imem_prog_ena;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;

  modport master (output imem_prog_ena, imem_we, imem_addr, imem_din);
  modport slave  (input  imem_prog_ena, imem_we, imem_addr, imem_din);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, baud counter and RX FSM.
// byte_valid / frame_err_pulse are single-cycle strobes in the stop-bit sample cycle.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       Rst_n,
  input  logic       enable,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_sync;
  rx_state_t        rx_state;
  rx_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_q;
  logic [2:0]       bit_d;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_state <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      rx_state <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    state_d         = rx_state;
    cnt_d           = cnt_q + 1'b1;
    bit_d           = bit_q;
    shift_d         = shift_q;
    byte_valid      = 1'b0;
    frame_err_pulse = 1'b0;
    if (!enable) begin
      // leaving programming mode abandons any frame in flight
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (rx_state)
        IDLE: begin
          cnt_d = '0;
          if (!rx_sync) state_d = START;
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_sync ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_sync, shift_q[7:1]};
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 3'd1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
            if (rx_sync) byte_valid      = 1'b1;
            else         frame_err_pulse = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads instruction words over UART into instruction memory while prog=1.
// Optional XOR checksum of written words: define UART_LOADER_CHECKSUM_EN.
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [31:0] START_ADDR   = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       Rst_n,
  input  logic                       prog,
  input  logic                       rx,
  uart_prog_loader_if.master         imem,
  output logic [15:0]                word_count,
  output logic                       frame_err,
  output logic [31:0]                checksum
);

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  frame_err_pulse;
  logic                  prog_q;
  logic                  prog_rise;
  logic [31:0]           addr_q;
  logic [BYTE_IDX_W-1:0] idx_q;
  logic [23:0]           lanes_q;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk             (clk),
    .Rst_n           (Rst_n),
    .enable          (prog),
    .rx              (rx),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .frame_err_pulse (frame_err_pulse)
  );

  assign prog_rise          = prog && !prog_q;
  assign imem.imem_prog_ena = prog_q;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prog_q         <= 1'b0;
      addr_q         <= START_ADDR;
      idx_q          <= '0;
      lanes_q        <= '0;
      word_count     <= '0;
      frame_err      <= 1'b0;
      imem.imem_we   <= 1'b0;
      imem.imem_addr <= '0;
      imem.imem_din  <= '0;
    end else begin
      prog_q       <= prog;
      imem.imem_we <= 1'b0;
      if (prog_rise) begin
        addr_q     <= START_ADDR;
        idx_q      <= '0;
        lanes_q    <= '0;
        word_count <= '0;
        frame_err  <= 1'b0;
      end else if (!prog) begin
        // a partial word never survives leaving programming mode
        idx_q <= '0;
      end else begin
        if (frame_err_pulse) frame_err <= 1'b1;
        if (byte_valid) begin
          idx_q <= idx_q + 1'b1;
          unique case (idx_q)
            2'd0: lanes_q[7:0]   <= byte_data;
            2'd1: lanes_q[15:8]  <= byte_data;
            2'd2: lanes_q[23:16] <= byte_data;
            default: begin
              imem.imem_we   <= 1'b1;
              imem.imem_din  <= {byte_data, lanes_q};
              imem.imem_addr <= addr_q;
              addr_q         <= addr_q + 32'd4;
              if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            end
          endcase
        end
      end
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n)            csum_q <= '0;
    else if (prog_rise)    csum_q <= '0;
    else if (imem.imem_we) csum_q <= csum_q ^ imem.imem_din;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed + randomized bench for uart_prog_loader against a byte-level reference model.
module tb_uart_prog_loader;
  import uart_loader_pkg::*;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        prog;
  logic        rx;
  logic [15:0] word_count;
  logic        frame_err;
  logic [31:0] checksum;

  uart_prog_loader_if imem_bus ();

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .START_ADDR  (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .Rst_n      (Rst_n),
    .prog       (prog),
    .rx         (rx),
    .imem       (imem_bus),
    .word_count (word_count),
    .frame_err  (frame_err),
    .checksum   (checksum)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: accepted bytes build words, words become expected writes
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [7:0]  mb_q[$];
  logic [31:0] m_addr;
  logic [15:0] m_count;
  logic        m_err;
  logic [31:0] m_csum;

  task automatic model_session_start();
    mb_q.delete();
    m_addr  = 32'h0;
    m_count = 16'h0;
    m_err   = 1'b0;
    m_csum  = 32'h0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic stop_ok);
    logic [31:0] w;
    if (!stop_ok) begin
      m_err = 1'b1;
    end else begin
      mb_q.push_back(b);
      if (mb_q.size() == 4) begin
        w = {mb_q[3], mb_q[2], mb_q[1], mb_q[0]};
        exp_q.push_back({m_addr, w});
        m_addr  = m_addr + 32'd4;
        m_count = (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
        m_csum  = m_csum ^ w;
        mb_q.delete();
      end
    end
  endtask

  // monitor: capture writes and check strobe legality away from the active edge
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (imem_bus.imem_we) begin
      obs_q.push_back({imem_bus.imem_addr, imem_bus.imem_din});
      check("we_while_ena", {63'd0, imem_bus.imem_prog_ena}, 64'd1);
      check("we_one_cycle", {63'd0, we_prev}, 64'd0);
    end
    we_prev = imem_bus.imem_we;
  end

  // driver tasks
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB + $urandom_range(0, 8)) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    drive_frame(b, stop_ok);
    model_byte(b, stop_ok);
  endtask

  task automatic set_prog(input logic v);
    prog = v;
    if (v) model_session_start();
    else   mb_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic new_session();
    set_prog(1'b0);
    set_prog(1'b1);
  endtask

  task automatic compare_session(input string tag);
    logic [63:0] o;
    logic [63:0] e;
    check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_write"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_word_count"}, 64'(word_count), 64'(m_count));
    check({tag, "_frame_err"}, 64'(frame_err), 64'(m_err));
`ifdef UART_LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, 64'(checksum), 64'(m_csum));
`else
    check({tag, "_checksum"}, 64'(checksum), 64'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ena_we"}, 64'({imem_bus.imem_prog_ena, imem_bus.imem_we}), 64'd0);
    check({tag, "_addr"}, 64'(imem_bus.imem_addr), 64'd0);
    check({tag, "_din"}, 64'(imem_bus.imem_din), 64'd0);
    check({tag, "_cnt_err"}, 64'({word_count, frame_err}), 64'd0);
    check({tag, "_checksum"}, 64'(checksum), 64'd0);
  endtask

  logic [7:0] rb;

  initial begin
    Rst_n = 1'b0;
    prog  = 1'b0;
    rx    = 1'b1;
    model_session_start();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_init");
    Rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // two words, little-endian assembly
    set_prog(1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
    check("two_words_nexp", 64'(exp_q.size()), 64'd2);
    compare_session("two_words");
    check("two_words_ena", 64'(imem_bus.imem_prog_ena), 64'd1);

    // short low glitch is rejected
    new_session();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_idle", 64'(dut.u_rx.rx_state), 64'(IDLE));
    compare_session("glitch");

    // frame error does not consume a byte lane
    new_session();
    send_byte(8'hAA, 1'b0);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    compare_session("frame_err");

    // partial word dropped when prog falls
    new_session();
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
    new_session();
    send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
    compare_session("prog_drop");

    // checksum of two words
    new_session();
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
`ifdef UART_LOADER_CHECKSUM_EN
    check("csum_value", 64'(checksum), 64'h0000_0000_EDCB_5678);
`else
    check("csum_value", 64'(checksum), 64'd0);
`endif
    compare_session("checksum");

    // reset in the middle of the second byte's data bits
    new_session();
    send_byte(8'h5A, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge clk);
    end
    Rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_mid");
    rx = 1'b1;
    model_session_start();
    obs_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    Rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'hC3, 1'b1); send_byte(8'hB2, 1'b1); send_byte(8'hA1, 1'b1); send_byte(8'h90, 1'b1);
    compare_session("after_reset");

    // randomized bytes with occasional framing errors
    new_session();
    for (int n = 0; n < 14; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_byte(rb, ($urandom_range(0, 5) != 0));
    end
    compare_session("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
